fetch_refill_controller: RTL and testbench

- Sequences I-cache line refills for the fetch stage on a miss at the head of the fetch group.
- Captures the miss address, issues one line-aligned read to the memory port, collects the response beats into a line buffer, and writes the full line into the I-cache array.
- Signals the fetch stage to hold its stall until the refill completes.
- Sits between the fetch stage's I-cache tag check and the shared memory request/response port.

---
 rtl/fetch_refill_controller_pkg.sv | 28 ++
 rtl/fetch_refill_line_buffer.sv | 33 +++
 rtl/fetch_refill_controller.sv | 132 +++++++++++++
 tb/tb_fetch_refill_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_refill_controller_pkg.sv
// Shared types and constants for the I-cache refill controller.
// The optional performance counters are enabled with RSD_REFILL_PERF_COUNTER_EN.
package fetch_refill_controller_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int WORD_WIDTH       = 32;
    localparam int LINE_WORDS       = 4;
    localparam int LINE_BYTES       = LINE_WORDS * WORD_WIDTH / 8;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int BEAT_IDX_BITS    = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } RefillState;

    typedef logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] RefillLinePath;

    function automatic logic [ADDR_WIDTH-1:0] ToLineAddr(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] line_addr;
        line_addr = addr;
        line_addr[LINE_OFFSET_BITS-1:0] = '0;
        return line_addr;
    endfunction

endpackage

// File: rtl/fetch_refill_line_buffer.sv
// Beat counter and line register that assemble in-order response beats into one cache line.
// Beat 0 lands in the least significant word.
module refill_line_buffer
    import fetch_refill_controller_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             write,
    input  logic                             clear,
    input  logic [WORD_WIDTH-1:0]            data,
    output logic                             last_beat,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] line
);

    logic [BEAT_IDX_BITS-1:0] count_q;
    RefillLinePath            line_q;

    assign last_beat = (count_q == BEAT_IDX_BITS'(LINE_WORDS - 1));
    assign line      = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            line_q  <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (write) begin
            line_q[count_q] <= data;
            count_q         <= last_beat ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_refill_controller.sv
// I-cache line refill sequencer: one line-aligned memory read per miss, line written in FILL.
// Define RSD_REFILL_PERF_COUNTER_EN to add the refillCount / refillStallCycles counters.
module fetch_refill_controller
    import fetch_refill_controller_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             missValid,
    input  logic [ADDR_WIDTH-1:0]            missAddr,
    input  logic                             flush,
    output logic                             refillBusy,
    output logic                             refillDone,
    output logic                             memReqValid,
    output logic [ADDR_WIDTH-1:0]            memReqAddr,
    input  logic                             memReqReady,
    input  logic                             memRespValid,
    input  logic [WORD_WIDTH-1:0]            memRespData,
    output logic                             icWE,
    output logic [ADDR_WIDTH-1:0]            icWriteAddr,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] icWriteData,
`ifdef RSD_REFILL_PERF_COUNTER_EN
    output logic [31:0]                      refillCount,
    output logic [31:0]                      refillStallCycles,
`endif
    output logic [1:0]                       refillState
);

    // Memory port handshake: a request transfers on the cycle memReqValid && memReqReady,
    // and address stays stable while waiting; response beats have no back-pressure.

    RefillState              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
    logic                    drop_q, drop_d;
    logic                    after_fill_q;
    logic                    refetch_hit;
    logic                    buf_write, buf_clear, buf_last;
    logic [LINE_WORDS*WORD_WIDTH-1:0] buf_line;

    refill_line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .write     (buf_write),
        .clear     (buf_clear),
        .data      (memRespData),
        .last_beat (buf_last),
        .line      (buf_line)
    );

    // The tag check still reports a miss for the line just written; it hits a cycle later.
    assign refetch_hit = after_fill_q && (ToLineAddr(missAddr) == line_addr_q);
    assign refillState = state_q;

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        drop_d      = drop_q;
        buf_write   = 1'b0;
        buf_clear   = 1'b0;
        refillBusy  = (state_q != IDLE);
        refillDone  = 1'b0;
        memReqValid = 1'b0;
        memReqAddr  = '0;
        icWE        = 1'b0;
        icWriteAddr = '0;
        icWriteData = '0;
        case (state_q)
            IDLE: begin
                buf_clear = 1'b1;
                if (missValid && !flush && !refetch_hit) begin
                    line_addr_d = ToLineAddr(missAddr);
                    state_d     = REQ;
                end
            end
            REQ: begin
                memReqValid = 1'b1;
                memReqAddr  = line_addr_q;
                if (memReqReady) begin
                    state_d = WAIT;
                    if (flush) drop_d = 1'b1;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                buf_write = memRespValid;
                if (flush) drop_d = 1'b1;
                if (memRespValid && buf_last) state_d = FILL;
            end
            FILL: begin
                icWE        = 1'b1;
                icWriteAddr = line_addr_q;
                icWriteData = buf_line;
                refillDone  = !drop_q;
                drop_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            drop_q       <= 1'b0;
            after_fill_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            drop_q       <= drop_d;
            after_fill_q <= (state_q == FILL);
        end
    end

`ifdef RSD_REFILL_PERF_COUNTER_EN
    logic [31:0] refill_count_q, stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            refill_count_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (state_q == FILL && refill_count_q != '1) refill_count_q <= refill_count_q + 32'd1;
            if (refillBusy && stall_cycles_q != '1)      stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign refillCount       = refill_count_q;
    assign refillStallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_refill_controller.sv
// Self-checking bench for fetch_refill_controller: scoreboard of expected line writes.
// Also checks the perf counters when RSD_REFILL_PERF_COUNTER_EN is defined.
module tb_fetch_refill_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         missValid;
    logic [31:0]  missAddr;
    logic         flush;
    logic         refillBusy, refillDone;
    logic         memReqValid;
    logic [31:0]  memReqAddr;
    logic         memReqReady;
    logic         memRespValid;
    logic [31:0]  memRespData;
    logic         icWE;
    logic [31:0]  icWriteAddr;
    logic [127:0] icWriteData;
    logic [1:0]   refillState;
`ifdef RSD_REFILL_PERF_COUNTER_EN
    logic [31:0]  refillCount, refillStallCycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int cyc      = 0;

    logic [31:0]  exp_addr_q[$];
    logic [127:0] exp_data_q[$];
    logic         exp_done_q[$];

    fetch_refill_controller dut (
        .clk               (clk),
        .rst               (rst),
        .missValid         (missValid),
        .missAddr          (missAddr),
        .flush             (flush),
        .refillBusy        (refillBusy),
        .refillDone        (refillDone),
        .memReqValid       (memReqValid),
        .memReqAddr        (memReqAddr),
        .memReqReady       (memReqReady),
        .memRespValid      (memRespValid),
        .memRespData       (memRespData),
        .icWE              (icWE),
        .icWriteAddr       (icWriteAddr),
        .icWriteData       (icWriteData),
`ifdef RSD_REFILL_PERF_COUNTER_EN
        .refillCount       (refillCount),
        .refillStallCycles (refillStallCycles),
`endif
        .refillState       (refillState)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] make_line(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [127:0] d, input logic done);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_done_q.push_back(done);
    endtask

    // One clock: count request transfers, advance, then score any line write.
    task automatic tick();
        logic [31:0]  ea;
        logic [127:0] ed;
        logic         edn;
        if (memReqValid && memReqReady && !rst) n_xfer++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (icWE) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_fill", 1'b1, 1'b0);
            end else begin
                ea  = exp_addr_q.pop_front();
                ed  = exp_data_q.pop_front();
                edn = exp_done_q.pop_front();
                check("fill_addr", icWriteAddr, ea);
                check("fill_data", icWriteData, ed);
                check("fill_done", refillDone, edn);
            end
        end else if (refillDone) begin
            check("done_without_fill", refillDone, 1'b0);
        end
    endtask

    task automatic start_miss(input logic [31:0] a);
        missValid = 1'b1;
        missAddr  = a;
        tick();
        missValid = 1'b0;
        missAddr  = $urandom;
    endtask

    task automatic send_line(input logic [31:0] base, input int gap);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) tick();
            memRespValid = 1'b1;
            memRespData  = base + 32'(i);
            tick();
            memRespValid = 1'b0;
            memRespData  = $urandom;
        end
    endtask

    initial begin
        int x0;
        int miss_cyc;
        logic [31:0] ra, rb;
        int rdly, rgap;

        rst = 1'b1; missValid = 1'b0; missAddr = '0; flush = 1'b0;
        memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_busy", refillBusy, 1'b0);
        check("rst_done", refillDone, 1'b0);
        check("rst_req_valid", memReqValid, 1'b0);
        check("rst_req_addr", memReqAddr, 32'h0);
        check("rst_icwe", icWE, 1'b0);
        check("rst_ic_addr", icWriteAddr, 32'h0);
        check("rst_ic_data", icWriteData, 128'h0);
        check("rst_state", refillState, 2'd0);
        rst = 1'b0;
        tick();

        // Basic refill with zero-wait memory
        memReqReady = 1'b1;
        push_exp(32'h1000_0010, 128'h000000A3_000000A2_000000A1_000000A0, 1'b1);
        miss_cyc = cyc;
        start_miss(32'h1000_0014);
        check("basic_req_valid", memReqValid, 1'b1);
        check("basic_req_addr", memReqAddr, 32'h1000_0010);
        check("basic_busy", refillBusy, 1'b1);
        tick();
        send_line(32'hA0, 0);
        check("basic_latency", 32'(cyc - miss_cyc), 32'd6);
        check("basic_icwe", icWE, 1'b1);
        check("basic_done", refillDone, 1'b1);
        tick();
        missValid = 1'b1;
        missAddr  = 32'h1000_0018;
        tick();
        missValid = 1'b0;
        check("refetch_ignored", refillBusy, 1'b0);

        // Request back-pressure
        memReqReady = 1'b0;
        push_exp(32'h3000_0040, make_line(32'h11), 1'b1);
        x0 = n_xfer;
        start_miss(32'h3000_0044);
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", memReqValid, 1'b1);
            check("bp_req_addr", memReqAddr, 32'h3000_0040);
            tick();
        end
        memReqReady = 1'b1;
        tick();
        check("bp_one_xfer", 32'(n_xfer - x0), 32'd1);
        check("bp_state_wait", refillState, 2'd2);
        check("bp_req_dropped", memReqValid, 1'b0);
        send_line(32'h11, 0);
        tick();
        check("bp_no_dup", 32'(n_xfer - x0), 32'd1);

        // Spurious beat in IDLE, then gapped response
        memRespValid = 1'b1;
        memRespData  = 32'hDEAD_BEEF;
        tick();
        memRespValid = 1'b0;
        check("spurious_idle", refillBusy, 1'b0);
        push_exp(32'h4000_0000, make_line(32'hB0), 1'b1);
        start_miss(32'h4000_0008);
        tick();
        send_line(32'hB0, 3);
        tick();

        // Flush in WAIT after beat 1: line written, done suppressed
        push_exp(32'h5000_0010, make_line(32'hD0), 1'b0);
        start_miss(32'h5000_001C);
        tick();
        for (int i = 0; i < 2; i++) begin
            memRespValid = 1'b1;
            memRespData  = 32'hD0 + 32'(i);
            tick();
        end
        memRespValid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 2; i < 4; i++) begin
            memRespValid = 1'b1;
            memRespData  = 32'hD0 + 32'(i);
            tick();
        end
        memRespValid = 1'b0;
        check("flush_wait_icwe", icWE, 1'b1);
        check("flush_wait_done", refillDone, 1'b0);
        tick();
        check("flush_wait_idle", refillBusy, 1'b0);

        // Flush in IDLE blocks a simultaneous miss
        missValid = 1'b1;
        missAddr  = 32'h5500_0000;
        flush     = 1'b1;
        tick();
        missValid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_no_start", refillBusy, 1'b0);

        // Flush in REQ before acceptance
        memReqReady = 1'b0;
        x0 = n_xfer;
        start_miss(32'h6000_0000);
        check("flush_req_valid", memReqValid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_req_state", refillState, 2'd0);
        check("flush_req_valid_off", memReqValid, 1'b0);
        memReqReady = 1'b1;
        repeat (4) tick();
        check("flush_req_no_xfer", 32'(n_xfer - x0), 32'd0);

        // Reset in WAIT, then a fresh miss
        start_miss(32'h7000_0000);
        tick();
        memRespValid = 1'b1;
        memRespData  = 32'h99;
        tick();
        memRespValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_idle", refillBusy, 1'b0);
        check("mid_rst_ic_data", icWriteData, 128'h0);
        push_exp(32'h2000_0000, make_line(32'hC0), 1'b1);
        start_miss(32'h2000_0000);
        check("post_rst_req_addr", memReqAddr, 32'h2000_0000);
        tick();
        send_line(32'hC0, 0);
        tick();
`ifdef RSD_REFILL_PERF_COUNTER_EN
        check("perf_refill_count", refillCount, 32'd1);
        check("perf_stall_cycles", refillStallCycles, 32'd6);
`endif

        // Random refills with random request delay and beat gaps
        for (int k = 0; k < 4; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            rdly = $urandom_range(0, 4);
            rgap = $urandom_range(0, 2);
            push_exp(line_of(ra), make_line(rb), 1'b1);
            memReqReady = 1'b0;
            start_miss(ra);
            check("rand_req_addr", memReqAddr, line_of(ra));
            repeat (rdly) tick();
            memReqReady = 1'b1;
            tick();
            send_line(rb, rgap);
            tick();
        end

        repeat (3) tick();
        check("pending_fills", 32'(exp_addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
